// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 load/store data memory with a valid/ready request
// channel, a valid/ready response channel, configurable depth and read
// latency, and fault reporting for illegal, out-of-range and misaligned
// accesses. One transaction outstanding at a time.
// Optional build macro DMEM_MISALIGN_EN: in-range misaligned halfword/word
// accesses complete (one extra cycle) instead of faulting.
module data_mem_ctrl #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned READ_LAT  = 1,
   parameter bit          INIT_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [2:0]        cnt;
   logic [31:0]       pend_data;
   logic              pend_err;

   logic              accept;
   logic              err;
   logic              f3_ok;
   logic              hi_ok;
   logic              range_ok;
   logic              align_ok;
   logic              misaligned;
   logic              sext;
   logic              extra;
   logic              wr_en;
   logic [1:0]        size_m1;
   logic [3:0]        be;
   logic [2:0]        total_lat;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] byte_addr [4];
   logic [7:0]        rd_byte [4];
   logic [31:0]       ld_data;
`ifdef DMEM_MISALIGN_EN
   logic [ADDR_W:0]   last_byte;
`endif

   assign req_ready = rst_n && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign offset    = req_addr[ADDR_W-1:0];

   // Decode funct3 into access size/extension and classify faults.
   always_comb begin
      f3_ok   = 1'b1;
      size_m1 = 2'd0;
      sext    = 1'b0;
      case (req_funct3)
         3'b000:  begin size_m1 = 2'd0; sext = 1'b1; end
         3'b001:  begin size_m1 = 2'd1; sext = 1'b1; end
         3'b010:  size_m1 = 2'd3;
         3'b100:  f3_ok = !req_we;
         3'b101:  begin size_m1 = 2'd1; f3_ok = !req_we; end
         default: f3_ok = 1'b0;
      endcase
      be = (size_m1 == 2'd0) ? 4'b0001 : (size_m1 == 2'd1) ? 4'b0011 : 4'b1111;
      hi_ok = (req_addr >> ADDR_W) == 32'd0;
      misaligned = ((size_m1 == 2'd1) && req_addr[0]) ||
                   ((size_m1 == 2'd3) && (req_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_EN
      // The last byte touched must still lie inside the array.
      last_byte = {1'b0, offset} + {{(ADDR_W-1){1'b0}}, size_m1};
      range_ok  = hi_ok && !last_byte[ADDR_W];
      align_ok  = 1'b1;
      extra     = misaligned;
`else
      range_ok  = hi_ok;
      align_ok  = !misaligned;
      extra     = 1'b0;
`endif
      err       = !f3_ok || !range_ok || !align_ok;
      wr_en     = accept && req_we && !err;
      total_lat = 3'(READ_LAT) + {2'b00, extra};
      for (int unsigned k = 0; k < 4; k++) begin
         byte_addr[k] = offset + ADDR_W'(k);
      end
   end

   if (INIT_ZERO) begin : g_mem_zero
      logic [7:0] arr [DEPTH] = '{default: 8'h00};

      // Store bytes land at the acceptance edge; contents survive reset.
      always_ff @(posedge clk) begin
         if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
               if (be[k]) arr[byte_addr[k]] <= req_wdata[8*k +: 8];
            end
         end
      end

      // Asynchronous read of the four candidate bytes.
      always_comb begin
         for (int unsigned k = 0; k < 4; k++) rd_byte[k] = arr[byte_addr[k]];
      end
   end else begin : g_mem_undef
      logic [7:0] arr [DEPTH];

      // Store bytes land at the acceptance edge; contents survive reset.
      always_ff @(posedge clk) begin
         if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
               if (be[k]) arr[byte_addr[k]] <= req_wdata[8*k +: 8];
            end
         end
      end

      // Asynchronous read of the four candidate bytes.
      always_comb begin
         for (int unsigned k = 0; k < 4; k++) rd_byte[k] = arr[byte_addr[k]];
      end
   end

   // Assemble and extend the addressed bytes; stores and faults return zero.
   always_comb begin
      ld_data = '0;
      case (size_m1)
         2'd0:    ld_data = {{24{sext & rd_byte[0][7]}}, rd_byte[0]};
         2'd1:    ld_data = {{16{sext & rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
         default: ld_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
      endcase
      if (req_we || err) ld_data = '0;
   end

   // Transaction FSM; load data is snapshotted at acceptance and replayed later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         pend_data <= '0;
         pend_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (total_lat > 3'd1) begin
                     state     <= WAIT;
                     cnt       <= total_lat - 3'd1;
                     pend_data <= ld_data;
                     pend_err  <= err;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= ld_data;
                     rsp_err   <= err;
                  end
               end
            end
            WAIT: begin
               if (cnt == 3'd1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= pend_data;
                  rsp_err   <= pend_err;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
